// File: rtl/pipelined_core_4stage.sv
// pipelined_core_4stage: four-stage IF/ID/EXE/WB integer pipeline.
// IF holds the PC. ID decodes the instruction straight off the synchronous imem and reads the
// write-through regfile. EXE runs the ALU and drives the data memory. WB writes the regfile.
// Build option PIPE_FORWARD_EN: when defined, the WB result (ALU or load data) is forwarded into
// the EXE operands, and stall is tied low. When undefined, a one-cycle interlock holds PC/ID and
// injects a bubble into EXE whenever ID reads the destination of the instruction now in EXE.
module pipelined_core_4stage #(
   parameter int DSIZE = 32,
   parameter int ASIZE = 5,
   parameter int ISIZE = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [ISIZE-1:0] imem_addr,
   output logic             imem_en,
   input  logic [31:0]      imem_rdata,
   output logic [DSIZE-1:0] dm_addr,
   output logic [DSIZE-1:0] dm_wdata,
   output logic             dm_wen,
   output logic             dm_ren,
   input  logic [DSIZE-1:0] dm_rdata,
   output logic             wb_en,
   output logic [ASIZE-1:0] wb_addr,
   output logic [DSIZE-1:0] wb_data,
   output logic             stall,
   output logic [31:0]      retired
);

   localparam int         NREGS   = 2 ** ASIZE;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // ALU operation; add/sub wrap, shift amounts use the low five bits of b
   function automatic logic [DSIZE-1:0] alu(input logic [DSIZE-1:0] a,
                                            input logic [DSIZE-1:0] b,
                                            input logic [2:0]       f);
      case (f)
         3'b000:  alu = a + b;
         3'b001:  alu = a - b;
         3'b010:  alu = a & b;
         3'b011:  alu = a | b;
         3'b100:  alu = a ^ b;
         3'b101:  alu = {{(DSIZE-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b110:  alu = a << b[4:0];
         default: alu = a >> b[4:0];
      endcase
   endfunction

   // IF state
   logic [ISIZE-1:0] pc_q, pc_d;
   logic             id_valid_q, id_valid_d;

   // register file (r0 is never written and always reads as zero)
   logic [DSIZE-1:0] rf_q [NREGS];

   // ID decode
   logic [5:0]        id_op;
   logic [4:0]        id_rs_f, id_rt_f, id_rd_f;
   logic [ASIZE-1:0]  id_rs, id_rt, id_rd, id_dest;
   logic signed [15:0] id_imm_s;
   logic [DSIZE-1:0]  id_imm, id_a, id_b;
   logic              id_is_r, id_is_addi, id_is_lw, id_is_sw, id_writes;

   // EXE stage registers
   logic             ex_valid_q, ex_valid_d;
   logic             ex_is_r_q, ex_is_lw_q, ex_is_sw_q, ex_writes_q;
   logic [2:0]       ex_func_q;
   logic [ASIZE-1:0] ex_dest_q;
   logic [DSIZE-1:0] ex_a_q, ex_b_q, ex_imm_q;
   logic [DSIZE-1:0] op_a, op_b, alu_b, alu_res;
   logic [2:0]       alu_f;
`ifdef PIPE_FORWARD_EN
   logic [ASIZE-1:0] ex_rs_q, ex_rt_q;
`endif

   // WB stage registers
   logic             wb_valid_q, wb_valid_d;
   logic             wb_writes_q, wb_store_q, wb_is_lw_q;
   logic [ASIZE-1:0] wb_addr_q;
   logic [DSIZE-1:0] wb_alu_q;
   logic [31:0]      retired_q, retired_d;

   assign id_op    = imem_rdata[31:26];
   assign id_rs_f  = imem_rdata[25:21];
   assign id_rt_f  = imem_rdata[20:16];
   assign id_rd_f  = imem_rdata[15:11];
   assign id_rs    = id_rs_f[ASIZE-1:0];
   assign id_rt    = id_rt_f[ASIZE-1:0];
   assign id_rd    = id_rd_f[ASIZE-1:0];
   assign id_imm_s = imem_rdata[15:0];
   assign id_imm   = DSIZE'(id_imm_s);

   // Instruction class decode; unknown opcodes decode as NOP (no write, no strobe)
   always_comb begin
      id_is_r    = (id_op == OP_R);
      id_is_addi = (id_op == OP_ADDI);
      id_is_lw   = (id_op == OP_LW);
      id_is_sw   = (id_op == OP_SW);
      id_writes  = id_is_r | id_is_addi | id_is_lw;
      if (id_is_r) begin
         id_dest = id_rd;
      end else begin
         id_dest = id_rt;
      end
   end

   // Regfile read ports with write-through of the same-cycle WB write
   always_comb begin
      id_a = '0;
      id_b = '0;
      if (id_rs == '0) begin
         id_a = '0;
      end else if (wb_en && (wb_addr_q == id_rs)) begin
         id_a = wb_data;
      end else begin
         id_a = rf_q[id_rs];
      end
      if (id_rt == '0) begin
         id_b = '0;
      end else if (wb_en && (wb_addr_q == id_rt)) begin
         id_b = wb_data;
      end else begin
         id_b = rf_q[id_rt];
      end
   end

`ifdef PIPE_FORWARD_EN
   assign stall = 1'b0;
`else
   logic id_reads_rs, id_reads_rt, hazard;

   // Interlock: ID sources a register that the instruction in EXE has yet to write back
   always_comb begin
      id_reads_rs = id_is_r | id_is_addi | id_is_lw | id_is_sw;
      id_reads_rt = id_is_r | id_is_sw;
      hazard      = 1'b0;
      if (id_valid_q && ex_valid_q && ex_writes_q && (ex_dest_q != '0)) begin
         hazard = (id_reads_rs && (id_rs == ex_dest_q)) ||
                  (id_reads_rt && (id_rt == ex_dest_q));
      end else begin
         hazard = 1'b0;
      end
   end

   assign stall = hazard;
`endif

   // EXE operand selection (WB forwarding when enabled) and ALU
   always_comb begin
      op_a = ex_a_q;
      op_b = ex_b_q;
`ifdef PIPE_FORWARD_EN
      if (wb_en && (wb_addr_q == ex_rs_q)) begin
         op_a = wb_data;
      end else begin
         op_a = ex_a_q;
      end
      if (wb_en && (wb_addr_q == ex_rt_q)) begin
         op_b = wb_data;
      end else begin
         op_b = ex_b_q;
      end
`endif
      if (ex_is_r_q) begin
         alu_b = op_b;
         alu_f = ex_func_q;
      end else begin
         alu_b = ex_imm_q;
         alu_f = 3'b000;
      end
      alu_res = alu(op_a, alu_b, alu_f);
   end

   // Next-state for PC, stage valids and the retire counter
   always_comb begin
      pc_d       = pc_q;
      id_valid_d = id_valid_q;
      if (stall) begin
         pc_d       = pc_q;
         id_valid_d = id_valid_q;
      end else begin
         pc_d       = pc_q + ISIZE'(1);
         id_valid_d = 1'b1;
      end
      ex_valid_d = id_valid_q & ~stall;
      wb_valid_d = ex_valid_q;
      if (wb_valid_q && (wb_writes_q || wb_store_q)) begin
         retired_d = retired_q + 32'd1;
      end else begin
         retired_d = retired_q;
      end
   end

   // Pipeline registers; reset squashes everything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= '0;
         id_valid_q  <= 1'b0;
         ex_valid_q  <= 1'b0;
         ex_is_r_q   <= 1'b0;
         ex_is_lw_q  <= 1'b0;
         ex_is_sw_q  <= 1'b0;
         ex_writes_q <= 1'b0;
         ex_func_q   <= 3'b000;
         ex_dest_q   <= '0;
         ex_a_q      <= '0;
         ex_b_q      <= '0;
         ex_imm_q    <= '0;
`ifdef PIPE_FORWARD_EN
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
`endif
         wb_valid_q  <= 1'b0;
         wb_writes_q <= 1'b0;
         wb_store_q  <= 1'b0;
         wb_is_lw_q  <= 1'b0;
         wb_addr_q   <= '0;
         wb_alu_q    <= '0;
         retired_q   <= 32'd0;
      end else begin
         pc_q        <= pc_d;
         id_valid_q  <= id_valid_d;
         ex_valid_q  <= ex_valid_d;
         ex_is_r_q   <= id_is_r;
         ex_is_lw_q  <= id_is_lw;
         ex_is_sw_q  <= id_is_sw;
         ex_writes_q <= id_writes;
         ex_func_q   <= imem_rdata[2:0];
         ex_dest_q   <= id_dest;
         ex_a_q      <= id_a;
         ex_b_q      <= id_b;
         ex_imm_q    <= id_imm;
`ifdef PIPE_FORWARD_EN
         ex_rs_q     <= id_rs;
         ex_rt_q     <= id_rt;
`endif
         wb_valid_q  <= wb_valid_d;
         wb_writes_q <= ex_writes_q;
         wb_store_q  <= ex_is_sw_q;
         wb_is_lw_q  <= ex_is_lw_q;
         wb_addr_q   <= ex_dest_q;
         wb_alu_q    <= alu_res;
         retired_q   <= retired_d;
      end
   end

   // Register file storage; writes to r0 never reach here because wb_en excludes them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_en) begin
         rf_q[wb_addr_q] <= wb_data;
      end
   end

   assign imem_addr = pc_q;
   assign imem_en   = ~stall;
   assign dm_addr   = alu_res;
   assign dm_wdata  = op_b;
   assign dm_wen    = ex_valid_q & ex_is_sw_q;
   assign dm_ren    = ex_valid_q & ex_is_lw_q;
   assign wb_en     = wb_valid_q & wb_writes_q & (wb_addr_q != '0);
   assign wb_addr   = wb_addr_q;
   assign wb_data   = wb_is_lw_q ? dm_rdata : wb_alu_q;
   assign retired   = retired_q;

endmodule
